// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_pkg
//  Description : Shared encodings, FSM state type and flag bundle for the
//                multi-cycle EX-stage ALU.
//  Revision    : 1.0  initial release
// ============================================================================
package alu_pkg;

    // alu_op field from the main decoder
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // R-type funct field values
    localparam logic [5:0] FUNCT_ADD  = 6'b100000;
    localparam logic [5:0] FUNCT_SUB  = 6'b100010;
    localparam logic [5:0] FUNCT_AND  = 6'b100100;
    localparam logic [5:0] FUNCT_OR   = 6'b100101;
    localparam logic [5:0] FUNCT_SLT  = 6'b101010;
    localparam logic [5:0] FUNCT_MUL  = 6'b011100;
    localparam logic [5:0] FUNCT_DIVU = 6'b011011;

    // 3-bit ALU control codes
    localparam logic [2:0] CTRL_AND  = 3'b000;
    localparam logic [2:0] CTRL_OR   = 3'b001;
    localparam logic [2:0] CTRL_ADD  = 3'b010;
    localparam logic [2:0] CTRL_DIVU = 3'b100;
    localparam logic [2:0] CTRL_MUL  = 3'b101;
    localparam logic [2:0] CTRL_SUB  = 3'b110;
    localparam logic [2:0] CTRL_SLT  = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } alu_state_t;

    // Status flags that travel with the registered result
    typedef struct packed {
        logic zero;
        logic div_by_zero;
    } alu_flags_t;

endpackage : alu_pkg
`default_nettype wire

// File: rtl/alu_func_dec.sv
`default_nettype none
// ============================================================================
//  Module      : alu_func_dec
//  Description : Combinational alu_op/funct to 3-bit ALU control decoder.
//                DIVU maps to ADD when the divider is not built.
//  Revision    : 1.0  initial release
// ============================================================================
module alu_func_dec
    import alu_pkg::*;
#(
    parameter int DIV_EN = 1
) (
    input  logic [1:0] alu_op_i,
    input  logic [5:0] funct_i,
    output logic [2:0] alu_control_o
);

    logic [2:0] w_divu_ctrl;

    generate
        if (DIV_EN != 0) begin : g_divu
            assign w_divu_ctrl = CTRL_DIVU;
        end else begin : g_no_divu
            assign w_divu_ctrl = CTRL_ADD;
        end
    endgenerate

    // alu_op selects add/sub directly; otherwise the funct field decides
    always_comb begin
        alu_control_o = CTRL_ADD;
        case (alu_op_i)
            ALUOP_ADD: alu_control_o = CTRL_ADD;
            ALUOP_SUB: alu_control_o = CTRL_SUB;
            default: begin
                case (funct_i)
                    FUNCT_ADD:  alu_control_o = CTRL_ADD;
                    FUNCT_SUB:  alu_control_o = CTRL_SUB;
                    FUNCT_AND:  alu_control_o = CTRL_AND;
                    FUNCT_OR:   alu_control_o = CTRL_OR;
                    FUNCT_SLT:  alu_control_o = CTRL_SLT;
                    FUNCT_MUL:  alu_control_o = CTRL_MUL;
                    FUNCT_DIVU: alu_control_o = w_divu_ctrl;
                    default:    alu_control_o = CTRL_ADD;
                endcase
            end
        endcase
    end

endmodule : alu_func_dec
`default_nettype wire

// File: rtl/alu_seq_unit.sv
`default_nettype none
// ============================================================================
//  Module      : alu_seq_unit
//  Description : Multi-cycle EX-stage ALU with valid/ready handshake, flush,
//                iterative shift-add multiplier and restoring divider.
//  Revision    : 1.0  initial release
// ============================================================================
module alu_seq_unit
    import alu_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int DIV_EN = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       alu_op,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             div_by_zero,
    output logic [2:0]       alu_control,
    output logic             busy
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    alu_state_t        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q;
    // MUL: acc = partial sum, opa = multiplicand (<<), opb = multiplier (>>)
    // DIV: acc = remainder,   opa = dividend -> quotient,  opb = divisor
    logic [WIDTH-1:0]  acc_q, opa_q, opb_q;
    logic [WIDTH-1:0]  result_q;
    alu_flags_t        flags_q;
    logic [2:0]        ctrl_q;

    logic [2:0]        w_ctrl;
    logic              w_accept;
    logic [WIDTH-1:0]  w_simple;
    logic [WIDTH-1:0]  w_mul_acc;
    logic [WIDTH:0]    w_div_shift;
    logic [WIDTH:0]    w_div_trial;
    logic              w_div_ok;
    logic [WIDTH-1:0]  w_div_rem;
    logic [WIDTH-1:0]  w_div_quo;

    alu_func_dec #(.DIV_EN(DIV_EN)) u_dec (
        .alu_op_i      (alu_op),
        .funct_i       (funct),
        .alu_control_o (w_ctrl)
    );

    assign w_accept = in_valid & in_ready;

    // Single-cycle operations, evaluated on the live operands at accept
    always_comb begin
        w_simple = src_a + src_b;
        case (w_ctrl)
            CTRL_AND: w_simple = src_a & src_b;
            CTRL_OR:  w_simple = src_a | src_b;
            CTRL_SUB: w_simple = src_a - src_b;
            CTRL_SLT: w_simple = {{(WIDTH-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
            default:  w_simple = src_a + src_b;
        endcase
    end

    // One multiplier step and one restoring-division step per cycle
    always_comb begin
        w_mul_acc   = opb_q[0] ? (acc_q + opa_q) : acc_q;
        w_div_shift = {acc_q, opa_q[WIDTH-1]};
        w_div_trial = w_div_shift - {1'b0, opb_q};
        w_div_ok    = ~w_div_trial[WIDTH];
        w_div_rem   = w_div_ok ? w_div_trial[WIDTH-1:0] : w_div_shift[WIDTH-1:0];
        w_div_quo   = {opa_q[WIDTH-2:0], w_div_ok};
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; flush overrides everything
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (w_accept) begin
                    if (w_ctrl == CTRL_MUL) begin
                        state_d = S_MUL;
                    end else if ((w_ctrl == CTRL_DIVU) && (src_b != '0)) begin
                        state_d = S_DIV;
                    end else begin
                        state_d = S_DONE;
                    end
                end else if (state_q == S_DONE && out_ready) begin
                    state_d = S_IDLE;
                end
            end
            S_MUL, S_DIV: begin
                if (cnt_q == '0) begin
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (flush) begin
            state_d = S_IDLE;
        end
    end

    // Handshake and status outputs decoded from the current state
    always_comb begin
        in_ready  = rst_n & ~flush &
                    ((state_q == S_IDLE) | ((state_q == S_DONE) & out_ready));
        out_valid = (state_q == S_DONE);
        busy      = (state_q == S_MUL) | (state_q == S_DIV);
    end

    // Operand latching, iteration datapath and registered result
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            acc_q    <= '0;
            opa_q    <= '0;
            opb_q    <= '0;
            result_q <= '0;
            flags_q  <= '0;
            ctrl_q   <= CTRL_ADD;
        end else if (flush) begin
            cnt_q <= '0;
        end else if (w_accept) begin
            ctrl_q <= w_ctrl;
            cnt_q  <= CNT_W'(WIDTH - 1);
            acc_q  <= '0;
            opa_q  <= src_a;
            opb_q  <= src_b;
            if (w_ctrl == CTRL_DIVU && src_b == '0) begin
                result_q <= '1;
                flags_q  <= '{zero: 1'b0, div_by_zero: 1'b1};
            end else if (w_ctrl != CTRL_MUL && w_ctrl != CTRL_DIVU) begin
                result_q <= w_simple;
                flags_q  <= '{zero: (w_simple == '0), div_by_zero: 1'b0};
            end
        end else if (state_q == S_MUL) begin
            acc_q <= w_mul_acc;
            opa_q <= {opa_q[WIDTH-2:0], 1'b0};
            opb_q <= {1'b0, opb_q[WIDTH-1:1]};
            if (cnt_q == '0) begin
                result_q <= w_mul_acc;
                flags_q  <= '{zero: (w_mul_acc == '0), div_by_zero: 1'b0};
            end else begin
                cnt_q <= cnt_q - CNT_W'(1);
            end
        end else if (state_q == S_DIV) begin
            acc_q <= w_div_rem;
            opa_q <= w_div_quo;
            if (cnt_q == '0) begin
                result_q <= w_div_quo;
                flags_q  <= '{zero: (w_div_quo == '0), div_by_zero: 1'b0};
            end else begin
                cnt_q <= cnt_q - CNT_W'(1);
            end
        end
    end

    assign result      = result_q;
    assign zero        = flags_q.zero;
    assign div_by_zero = flags_q.div_by_zero;
    assign alu_control = ctrl_q;

endmodule : alu_seq_unit
`default_nettype wire
